mesi_coherence_monitor: RTL and testbench

MESI_COHERENCE_MONITOR -- requirements
Module: mesi_coherence_monitor

---
 rtl/mesi_coherence_monitor.sv | 166 ++++++++++++++++
 tb/tb_mesi_coherence_monitor.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_coherence_monitor.sv
// MESI coherence monitor: registers a cache-state snapshot, then flags incoherent lines one cycle later.
// Optional per-CPU instruction-handshake watchdog is built when `MESI_MON_TIMEOUT_EN is defined.
module mesi_coherence_monitor #(
    parameter int CPU_COUNT  = 4,
    parameter int LINE_COUNT = 10,
    parameter int CNT_WIDTH  = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable_i,
    input  logic                              clr_i,
    input  logic [CPU_COUNT*LINE_COUNT*4-1:0] cache_state_i,
    input  logic [CPU_COUNT*4-1:0]            tb_ins_i,
    input  logic [CPU_COUNT-1:0]              tb_ins_ack_i,
    output logic                              viol_o,
    output logic                              viol_sticky_o,
    output logic [5:0]                        viol_line_o,
    output logic [1:0]                        viol_type_o,
    output logic [CNT_WIDTH-1:0]              viol_cnt_o,
    output logic [CPU_COUNT-1:0]              timeout_o
);
    localparam int SW = CPU_COUNT * LINE_COUNT * 4;
    localparam logic [3:0] ST_M = 4'b1000;
    localparam logic [3:0] ST_E = 4'b0100;
    localparam logic [3:0] ST_S = 4'b0010;
    localparam logic [3:0] ST_I = 4'b0001;
    localparam logic [SW-1:0] SNAP_RST = {(CPU_COUNT * LINE_COUNT){ST_I}};

    logic [SW-1:0]        snap_q, snap_d;
    logic                 en_q, en_d;
    logic                 viol_q, viol_d;
    logic                 sticky_q, sticky_d;
    logic [5:0]           line_q, line_d;
    logic [1:0]           type_q, type_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic       hit;
    logic [5:0] hit_line;
    logic [1:0] hit_type;
    logic [3:0] n_own, n_shr, fld;
    logic       bad_enc;

    always_comb begin
        snap_d = cache_state_i;
        en_d   = enable_i;
    end

    // Scan lines in ascending order so the lowest incoherent line is the one reported.
    always_comb begin
        hit      = 1'b0;
        hit_line = '0;
        hit_type = '0;
        n_own    = '0;
        n_shr    = '0;
        fld      = '0;
        bad_enc  = 1'b0;
        for (int l = 0; l < LINE_COUNT; l++) begin
            n_own   = '0;
            n_shr   = '0;
            bad_enc = 1'b0;
            for (int c = 0; c < CPU_COUNT; c++) begin
                fld = snap_q[(c*LINE_COUNT+l)*4 +: 4];
                case (fld)
                    ST_M, ST_E: n_own = n_own + 4'd1;
                    ST_S:       n_shr = n_shr + 4'd1;
                    ST_I:       ;
                    default:    bad_enc = 1'b1;
                endcase
            end
            if (!hit) begin
                if (bad_enc) begin
                    hit = 1'b1; hit_line = 6'(l); hit_type = 2'd0;
                end else if (n_own > 4'd1) begin
                    hit = 1'b1; hit_line = 6'(l); hit_type = 2'd1;
                end else if (n_own == 4'd1 && n_shr != 4'd0) begin
                    hit = 1'b1; hit_line = 6'(l); hit_type = 2'd2;
                end
            end
        end
    end

    // A clear is applied first so a coincident violation re-captures into freshly cleared state.
    always_comb begin
        viol_d   = en_q && hit;
        sticky_d = sticky_q;
        line_d   = line_q;
        type_d   = type_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            sticky_d = 1'b0;
            line_d   = '0;
            type_d   = '0;
            cnt_d    = '0;
        end
        if (viol_d) begin
            if (!sticky_d) begin
                line_d = hit_line;
                type_d = hit_type;
            end
            sticky_d = 1'b1;
            if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q   <= SNAP_RST;
            en_q     <= 1'b0;
            viol_q   <= 1'b0;
            sticky_q <= 1'b0;
            line_q   <= '0;
            type_q   <= '0;
            cnt_q    <= '0;
        end else begin
            snap_q   <= snap_d;
            en_q     <= en_d;
            viol_q   <= viol_d;
            sticky_q <= sticky_d;
            line_q   <= line_d;
            type_q   <= type_d;
            cnt_q    <= cnt_d;
        end
    end

    assign viol_o        = viol_q;
    assign viol_sticky_o = sticky_q;
    assign viol_line_o   = line_q;
    assign viol_type_o   = type_q;
    assign viol_cnt_o    = cnt_q;

`ifdef MESI_MON_TIMEOUT_EN
    logic [CPU_COUNT-1:0][15:0] wd_q, wd_d;
    logic [CPU_COUNT-1:0]       to_q, to_d;

    always_comb begin
        wd_d = wd_q;
        to_d = to_q;
        if (clr_i) to_d = '0;
        for (int c = 0; c < CPU_COUNT; c++) begin
            if (tb_ins_ack_i[c] || tb_ins_i[c*4 +: 4] == 4'd0) begin
                wd_d[c] = '0;
            end else if (enable_i && wd_q[c] != 16'(TIMEOUT)) begin
                wd_d[c] = wd_q[c] + 16'd1;
            end
            if (enable_i && wd_q[c] == 16'(TIMEOUT)) to_d[c] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
            to_q <= '0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign timeout_o = to_q;
`else
    logic unused_tb;
    assign unused_tb = ^{tb_ins_i, tb_ins_ack_i};
    assign timeout_o = '0;
`endif
endmodule

// File: tb/tb_mesi_coherence_monitor.sv
// Bench for mesi_coherence_monitor: directed scenarios plus randomized snapshots scored against a reference model.
`timescale 1ns/1ps
module tb_mesi_coherence_monitor;
    localparam int CPUS  = 4;
    localparam int LINES = 10;
    localparam int CW    = 4;
    localparam int TO    = 8;
    localparam int SW    = CPUS * LINES * 4;
    localparam logic [3:0] M = 4'b1000;
    localparam logic [3:0] E = 4'b0100;
    localparam logic [3:0] S = 4'b0010;
    localparam logic [3:0] I = 4'b0001;
    localparam logic [SW-1:0] ALL_I = {(CPUS * LINES){4'b0001}};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en  = 1'b0;
    logic            clr = 1'b0;
    logic [SW-1:0]   cs  = ALL_I;
    logic [CPUS*4-1:0] ins = '0;
    logic [CPUS-1:0] ack = '0;

    logic            viol_o, viol_sticky_o;
    logic [5:0]      viol_line_o;
    logic [1:0]      viol_type_o;
    logic [CW-1:0]   viol_cnt_o;
    logic [CPUS-1:0] timeout_o;

    mesi_coherence_monitor #(
        .CPU_COUNT(CPUS), .LINE_COUNT(LINES), .CNT_WIDTH(CW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(en), .clr_i(clr),
        .cache_state_i(cs), .tb_ins_i(ins), .tb_ins_ack_i(ack),
        .viol_o(viol_o), .viol_sticky_o(viol_sticky_o), .viol_line_o(viol_line_o),
        .viol_type_o(viol_type_o), .viol_cnt_o(viol_cnt_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    logic [SW-1:0]   m_snap;
    logic            m_en, m_viol, m_sticky;
    logic [5:0]      m_line;
    logic [1:0]      m_type;
    logic [CW-1:0]   m_cnt;
    logic [CPUS-1:0] m_to;
    int              m_wait [CPUS];

    function automatic void classify(input logic [SW-1:0] s, output logic bad,
                                     output logic [5:0] ln, output logic [1:0] ty);
        bad = 1'b0; ln = '0; ty = '0;
        for (int l = 0; l < LINES; l++) begin
            int nm, ne, ns, nill, t;
            logic [3:0] v;
            nm = 0; ne = 0; ns = 0; nill = 0;
            for (int c = 0; c < CPUS; c++) begin
                v = s[(c*LINES+l)*4 +: 4];
                if (v == M) nm++;
                else if (v == E) ne++;
                else if (v == S) ns++;
                else if (v != I) nill++;
            end
            if (nill > 0) t = 0;
            else if (nm + ne > 1) t = 1;
            else if (nm + ne == 1 && ns > 0) t = 2;
            else t = -1;
            if (t >= 0 && !bad) begin
                bad = 1'b1; ln = 6'(l); ty = 2'(t);
            end
        end
    endfunction

    task automatic step();
        logic bad;
        logic [5:0] ln;
        logic [1:0] ty;
`ifdef MESI_MON_TIMEOUT_EN
        logic [3:0] code;
`endif
        classify(m_snap, bad, ln, ty);
        if (rst) begin
            m_snap = ALL_I; m_en = 1'b0; m_viol = 1'b0; m_sticky = 1'b0;
            m_line = '0; m_type = '0; m_cnt = '0; m_to = '0;
            for (int i = 0; i < CPUS; i++) m_wait[i] = 0;
        end else begin
            if (clr) begin
                m_sticky = 1'b0; m_line = '0; m_type = '0; m_cnt = '0; m_to = '0;
            end
            m_viol = m_en && bad;
            if (m_viol) begin
                if (!m_sticky) begin m_line = ln; m_type = ty; end
                m_sticky = 1'b1;
                if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
            end
`ifdef MESI_MON_TIMEOUT_EN
            for (int i = 0; i < CPUS; i++) begin
                code = ins[i*4 +: 4];
                if (en && m_wait[i] == TO) m_to[i] = 1'b1;
                if (ack[i] || code == 4'd0) m_wait[i] = 0;
                else if (en && m_wait[i] < TO) m_wait[i]++;
            end
`endif
            m_snap = cs;
            m_en   = en;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_cell(input int c, input int l, input logic [3:0] v);
        cs[(c*LINES+l)*4 +: 4] = v;
    endtask

    task automatic clean_slate();
        rst = 1'b0; en = 1'b1; clr = 1'b0; cs = ALL_I; ins = '0; ack = '0;
        step(); step();
        clr = 1'b1; step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cs = ALL_I; en = 1'b1;
        step(); step();
        checks++; if (viol_o !== 1'b0) begin errors++; $display("FAIL reset_viol got %0b want 0", viol_o); end
        checks++; if (viol_sticky_o !== 1'b0) begin errors++; $display("FAIL reset_sticky got %0b want 0", viol_sticky_o); end
        checks++; if (viol_line_o !== 6'd0) begin errors++; $display("FAIL reset_line got %0d want 0", viol_line_o); end
        checks++; if (viol_type_o !== 2'd0) begin errors++; $display("FAIL reset_type got %0d want 0", viol_type_o); end
        checks++; if (viol_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", viol_cnt_o); end
        checks++; if (timeout_o !== 4'd0) begin errors++; $display("FAIL reset_timeout got %b want 0000", timeout_o); end
        rst = 1'b0;
    endtask

    task automatic test_owner_sharer();
        clean_slate();
        set_cell(0, 3, M); set_cell(1, 3, S);
        step();
        checks++; if (viol_o !== 1'b0) begin errors++; $display("FAIL os_early got %0b want 0", viol_o); end
        cs = ALL_I;
        step();
        checks++; if (viol_o !== 1'b1) begin errors++; $display("FAIL os_viol got %0b want 1", viol_o); end
        checks++; if (viol_line_o !== 6'd3) begin errors++; $display("FAIL os_line got %0d want 3", viol_line_o); end
        checks++; if (viol_type_o !== 2'd2) begin errors++; $display("FAIL os_type got %0d want 2", viol_type_o); end
        checks++; if (viol_cnt_o !== 4'd1) begin errors++; $display("FAIL os_cnt got %0d want 1", viol_cnt_o); end
        step();
        checks++; if (viol_o !== 1'b0) begin errors++; $display("FAIL os_pulse got %0b want 0", viol_o); end
        checks++; if (viol_sticky_o !== 1'b1) begin errors++; $display("FAIL os_sticky got %0b want 1", viol_sticky_o); end
    endtask

    task automatic test_multi_line();
        clean_slate();
        set_cell(1, 0, 4'b0011); set_cell(2, 5, E); set_cell(3, 5, M);
        step();
        cs = ALL_I;
        step();
        checks++; if (viol_o !== 1'b1) begin errors++; $display("FAIL ml_viol got %0b want 1", viol_o); end
        checks++; if (viol_line_o !== 6'd0) begin errors++; $display("FAIL ml_line got %0d want 0", viol_line_o); end
        checks++; if (viol_type_o !== 2'd0) begin errors++; $display("FAIL ml_type got %0d want 0", viol_type_o); end
        step();
        checks++; if (viol_cnt_o !== 4'd1) begin errors++; $display("FAIL ml_cnt got %0d want 1", viol_cnt_o); end
    endtask

    task automatic test_clr_collision();
        clean_slate();
        set_cell(0, 3, M); set_cell(1, 3, S);
        step(); step(); step();
        checks++; if (viol_cnt_o !== 4'd2) begin errors++; $display("FAIL clr_pre_cnt got %0d want 2", viol_cnt_o); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (viol_cnt_o !== 4'd1) begin errors++; $display("FAIL clr_cnt got %0d want 1", viol_cnt_o); end
        checks++; if (viol_sticky_o !== 1'b1) begin errors++; $display("FAIL clr_sticky got %0b want 1", viol_sticky_o); end
        checks++; if (viol_line_o !== 6'd3 || viol_type_o !== 2'd2) begin
            errors++; $display("FAIL clr_capture got line %0d type %0d want line 3 type 2", viol_line_o, viol_type_o);
        end
        cs = ALL_I;
        step(); step();
    endtask

    task automatic test_saturation();
        clean_slate();
        set_cell(2, 9, E); set_cell(3, 9, E);
        for (int i = 0; i < 20; i++) step();
        checks++; if (viol_cnt_o !== 4'hF) begin errors++; $display("FAIL sat_cnt got %0h want f", viol_cnt_o); end
        checks++; if (viol_line_o !== 6'd9 || viol_type_o !== 2'd1) begin
            errors++; $display("FAIL sat_capture got line %0d type %0d want line 9 type 1", viol_line_o, viol_type_o);
        end
        cs = ALL_I;
        step(); step();
    endtask

    task automatic test_enable();
        clean_slate();
        en = 1'b0;
        set_cell(0, 7, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (viol_o !== 1'b0) begin errors++; $display("FAIL en_viol step %0d got %0b want 0", i, viol_o); end
        end
        checks++; if (viol_sticky_o !== 1'b0 || viol_cnt_o !== 4'd0) begin
            errors++; $display("FAIL en_state got sticky %0b cnt %0d want 0 0", viol_sticky_o, viol_cnt_o);
        end
        cs = ALL_I; en = 1'b1;
        step(); step();
    endtask

    task automatic test_reset_flush();
        clean_slate();
        set_cell(1, 4, M); set_cell(2, 4, M);
        step();
        rst = 1'b1; cs = ALL_I;
        step();
        rst = 1'b0;
        checks++; if (viol_o !== 1'b0) begin errors++; $display("FAIL rf_viol_rst got %0b want 0", viol_o); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (viol_o !== 1'b0) begin errors++; $display("FAIL rf_viol_after step %0d got %0b want 0", i, viol_o); end
        end
        checks++; if (viol_sticky_o !== 1'b0 || viol_cnt_o !== 4'd0 || viol_line_o !== 6'd0 || viol_type_o !== 2'd0) begin
            errors++; $display("FAIL rf_state got sticky %0b cnt %0d line %0d type %0d want all 0",
                               viol_sticky_o, viol_cnt_o, viol_line_o, viol_type_o);
        end
    endtask

    task automatic test_timeout();
        clean_slate();
`ifdef MESI_MON_TIMEOUT_EN
        ins[11:8] = 4'h1;
        for (int i = 0; i < 10; i++) step();
        checks++; if (timeout_o !== 4'b0100) begin errors++; $display("FAIL to_set got %b want 0100", timeout_o); end
        ins = '0; clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (timeout_o !== 4'b0000) begin errors++; $display("FAIL to_clr got %b want 0000", timeout_o); end
        ins[11:8] = 4'h1;
        for (int i = 0; i < 6; i++) step();
        ack[2] = 1'b1; step(); ack[2] = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++; if (timeout_o !== 4'b0000) begin errors++; $display("FAIL to_ack got %b want 0000", timeout_o); end
`else
        ins[11:8] = 4'h1;
        for (int i = 0; i < 12; i++) step();
        checks++; if (timeout_o !== 4'b0000) begin errors++; $display("FAIL to_off got %b want 0000", timeout_o); end
`endif
        ins = '0;
        step();
    endtask

    task automatic rand_inputs();
        int r;
        cs = ALL_I;
        if ($urandom_range(0, 99) >= 30) begin
            for (int c = 0; c < CPUS; c++) begin
                for (int l = 0; l < LINES; l++) begin
                    r = $urandom_range(0, 99);
                    if (r < 75) set_cell(c, l, I);
                    else if (r < 88) set_cell(c, l, S);
                    else if (r < 94) set_cell(c, l, E);
                    else if (r < 98) set_cell(c, l, M);
                    else set_cell(c, l, 4'($urandom_range(0, 15)));
                end
            end
        end
        en  = ($urandom_range(0, 99) < 85);
        clr = ($urandom_range(0, 99) < 8);
        rst = ($urandom_range(0, 99) < 2);
        for (int c = 0; c < CPUS; c++) begin
            ins[c*4 +: 4] = ($urandom_range(0, 99) < 75) ? 4'($urandom_range(1, 15)) : 4'd0;
            ack[c] = ($urandom_range(0, 99) < 8);
        end
    endtask

    task automatic test_random();
        clean_slate();
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            step();
            checks++; if (viol_o !== m_viol) begin errors++; $display("FAIL rnd_viol cyc %0d got %0b want %0b", cyc, viol_o, m_viol); end
            checks++; if (viol_sticky_o !== m_sticky) begin errors++; $display("FAIL rnd_sticky cyc %0d got %0b want %0b", cyc, viol_sticky_o, m_sticky); end
            checks++; if (viol_line_o !== m_line) begin errors++; $display("FAIL rnd_line cyc %0d got %0d want %0d", cyc, viol_line_o, m_line); end
            checks++; if (viol_type_o !== m_type) begin errors++; $display("FAIL rnd_type cyc %0d got %0d want %0d", cyc, viol_type_o, m_type); end
            checks++; if (viol_cnt_o !== m_cnt) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", cyc, viol_cnt_o, m_cnt); end
            checks++; if (timeout_o !== m_to) begin errors++; $display("FAIL rnd_timeout cyc %0d got %b want %b", cyc, timeout_o, m_to); end
        end
        rst = 1'b0; clr = 1'b0; en = 1'b1; cs = ALL_I; ins = '0; ack = '0;
    endtask

    initial begin
        test_reset();
        test_owner_sharer();
        test_multi_line();
        test_clr_collision();
        test_saturation();
        test_enable();
        test_reset_flush();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
